// File: rtl/lorenz_plot_pkg.sv
// Shared types and fixed-point constants for the Lorenz attractor plotter.
// State vectors are signed 7.20; the Z offset recentres the butterfly vertically.
package lorenz_plot_pkg;
    localparam int DATA_W = 27;
    localparam int FRAC_W = 20;
    localparam logic [DATA_W-1:0] Z_CENTER = 27'h1900000;

    typedef enum logic [1:0] {
        PROJ_XY = 2'b00,
        PROJ_XZ = 2'b01,
        PROJ_YZ = 2'b10
    } proj_t;

    typedef enum logic [1:0] {
        CLEAR,
        WAIT,
        PROJ,
        WRITE
    } plot_state_t;
endpackage

// File: rtl/plot_project.sv
// Combinational 2-D projection of a latched state vector onto screen coordinates.
// Scaling is a pure arithmetic shift (floor), so no rounding or clamping happens here.
module plot_project
    import lorenz_plot_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [DATA_W-1:0] z,
    input  logic [1:0]        proj_sel,
    input  logic [2:0]        scale_shift,
    output logic [9:0]        pix_x,
    output logic [8:0]        pix_y,
    output logic              on_screen
);
    localparam logic signed [16:0] CX    = 17'(SCREEN_W / 2);
    localparam logic signed [16:0] CY    = 17'(SCREEN_H / 2);
    localparam logic signed [16:0] X_MAX = 17'(SCREEN_W - 1);
    localparam logic signed [16:0] Y_MAX = 17'(SCREEN_H - 1);

    // One extra bit so Z - Z_CENTER cannot wrap for any 7.20 input.
    logic signed [DATA_W:0] h_src, v_src, z_rel;
    logic [4:0]             shamt;
    logic signed [15:0]     h, v;
    logic signed [16:0]     px, py;

    assign z_rel = {z[DATA_W-1], z} - {1'b0, Z_CENTER};

    always_comb begin
        h_src = {x[DATA_W-1], x};
        v_src = {y[DATA_W-1], y};
        case (proj_t'(proj_sel))
            PROJ_XZ: v_src = z_rel;
            PROJ_YZ: begin
                h_src = {y[DATA_W-1], y};
                v_src = z_rel;
            end
            default: ;
        endcase
    end

    // Worst case magnitude after a 13-bit shift is 2^14, so 16 bits always hold it.
    assign shamt = 5'(FRAC_W) - {2'b00, scale_shift};
    assign h     = 16'(h_src >>> shamt);
    assign v     = 16'(v_src >>> shamt);

    assign px = CX + 17'(h);
    assign py = CY - 17'(v);

    assign on_screen = (px >= 17'sd0) && (px <= X_MAX) && (py >= 17'sd0) && (py <= Y_MAX);
    assign pix_x     = px[9:0];
    assign pix_y     = py[8:0];
endmodule

// File: rtl/lorenz_plotter.sv
// Plots decimated Lorenz states as pixel writes, throttling the integrator via step_en.
// Capture to pix_valid is 2 cycles; a stalled write holds pix_* and keeps step_en low.
module lorenz_plotter
    import lorenz_plot_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              state_valid,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] y_in,
    input  logic [DATA_W-1:0] z_in,
    input  logic [1:0]        proj_sel,
    input  logic [2:0]        scale_shift,
    input  logic [7:0]        decim,
    input  logic              clear_req,
    output logic              step_en,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [9:0]        pix_x,
    output logic [8:0]        pix_y,
    output logic [7:0]        pix_color,
    output logic              busy,
    output logic [15:0]       drop_cnt
);
    localparam logic [9:0] X_LAST = 10'(SCREEN_W - 1);
    localparam logic [8:0] Y_LAST = 9'(SCREEN_H - 1);

    plot_state_t       state, state_nxt;
    logic [DATA_W-1:0] x_lat, y_lat, z_lat;
    logic [7:0]        dec_cnt, dec_lim, col_cnt;
    logic [8:0]        cnt_inc;
    logic              clear_pend, restart, capture, sweep_last;
    logic [9:0]        prj_x;
    logic [8:0]        prj_y;
    logic              on_screen;

    plot_project #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_project (
        .x           (x_lat),
        .y           (y_lat),
        .z           (z_lat),
        .proj_sel    (proj_sel),
        .scale_shift (scale_shift),
        .pix_x       (prj_x),
        .pix_y       (prj_y),
        .on_screen   (on_screen)
    );

    assign dec_lim    = (decim == 8'd0) ? 8'd1 : decim;
    assign cnt_inc    = {1'b0, dec_cnt} + 9'd1;
    // >= rather than == so lowering decim below the running count still captures.
    assign capture    = (state == WAIT) && state_valid && !clear_req && (cnt_inc >= {1'b0, dec_lim});
    assign restart    = clear_req || clear_pend;
    assign sweep_last = (pix_x == X_LAST) && (pix_y == Y_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR: if (pix_valid && pix_ready && !restart && sweep_last) state_nxt = WAIT;
            WAIT: begin
                if (clear_req)    state_nxt = CLEAR;
                else if (capture) state_nxt = PROJ;
            end
            PROJ: begin
                if (on_screen)    state_nxt = WRITE;
                else              state_nxt = restart ? CLEAR : WAIT;
            end
            WRITE: if (pix_ready) state_nxt = restart ? CLEAR : WAIT;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_color  <= '0;
            step_en    <= 1'b0;
            busy       <= 1'b1;
            drop_cnt   <= '0;
            dec_cnt    <= '0;
            col_cnt    <= '0;
            clear_pend <= 1'b0;
            x_lat      <= '0;
            y_lat      <= '0;
            z_lat      <= '0;
        end else begin
            state   <= state_nxt;
            step_en <= (state_nxt == WAIT);
            busy    <= (state_nxt == CLEAR);
            case (state)
                CLEAR: begin
                    pix_valid <= 1'b1;
                    pix_color <= '0;
                    if (clear_req) clear_pend <= 1'b1;
                    if (pix_valid && pix_ready) begin
                        if (restart) begin
                            pix_x      <= '0;
                            pix_y      <= '0;
                            clear_pend <= 1'b0;
                        end else if (pix_x == X_LAST) begin
                            pix_x <= '0;
                            if (sweep_last) begin
                                pix_y     <= '0;
                                pix_valid <= 1'b0;
                            end else begin
                                pix_y <= pix_y + 9'd1;
                            end
                        end else begin
                            pix_x <= pix_x + 10'd1;
                        end
                    end
                end
                WAIT: begin
                    if (state_valid && !clear_req) begin
                        if (capture) begin
                            dec_cnt <= '0;
                            x_lat   <= x_in;
                            y_lat   <= y_in;
                            z_lat   <= z_in;
                        end else begin
                            dec_cnt <= cnt_inc[7:0];
                        end
                    end
                end
                PROJ: begin
                    if (clear_req) clear_pend <= 1'b1;
                    if (on_screen) begin
                        pix_x     <= prj_x;
                        pix_y     <= prj_y;
                        pix_color <= col_cnt;
                        pix_valid <= 1'b1;
                    end else if (drop_cnt != 16'hFFFF) begin
                        drop_cnt <= drop_cnt + 16'd1;
                    end
                end
                WRITE: begin
                    if (clear_req) clear_pend <= 1'b1;
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        col_cnt   <= col_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
            // Any entry into CLEAR from another state starts a fresh sweep at the origin.
            if (state != CLEAR && state_nxt == CLEAR) begin
                pix_x      <= '0;
                pix_y      <= '0;
                pix_color  <= '0;
                pix_valid  <= 1'b1;
                clear_pend <= 1'b0;
            end
        end
    end
endmodule

// File: doc/lorenz_plotter.md
Name: lorenz_plotter

Overview:
Consumes the Lorenz state vector (X, Y, Z in signed 7.20 fixed point, 27 bits) produced by the integrator stage. It projects that vector onto a 2-D screen plane and emits pixel write requests to the frame-buffer writer over a valid/ready handshake.
It throttles the integrator through step_en so that no state is lost while a write is stalled. After reset, and whenever requested, it clears the screen.

Parameters:
DATA_W, 27, width of state inputs (signed 7.20)
FRAC_W, 20, fractional bits of state inputs
SCREEN_W, 640, horizontal pixel count
SCREEN_H, 480, vertical pixel count
Z_CENTER, 25.0 in 7.20 (27'h1900000), value subtracted from Z before projection

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
state_valid  in  1  one-cycle pulse: x_in/y_in/z_in hold a newly integrated state
x_in  in  27  state X, signed 7.20
y_in  in  27  state Y, signed 7.20
z_in  in  27  state Z, signed 7.20
proj_sel  in  2  projection: 00 XY, 01 XZ, 10 YZ, 11 treated as XY
scale_shift  in  3  pixel scale = 2^scale_shift pixels per unit
decim  in  8  plot one of every decim states; 0 is treated as 1
clear_req  in  1  pulse: request a full-screen clear
step_en  out  1  integrator may advance this cycle
pix_valid  out  1  pixel write request
pix_ready  in  1  frame-buffer writer accepts the request
pix_x  out  10  pixel column
pix_y  out  9  pixel row
pix_color  out  8  pixel colour
busy  out  1  high while clearing
drop_cnt  out  16  saturating count of off-screen points

Behaviour:
- Clock is clk. Reset is synchronous and active-high (reset=1 sampled at the clk edge). All outputs are registered.
- Reset values: pix_valid=0, pix_x=0, pix_y=0, pix_color=0, step_en=0, busy=1, drop_cnt=0, decimation counter=0, colour counter=0. The FSM enters CLEAR.
- FSM states:
  - CLEAR: sweep row-major from (0,0) to (SCREEN_W-1, SCREEN_H-1) with pix_color=0. Advance one pixel per accepted transfer. After the (639,479) transfer, go to WAIT. busy=1, step_en=0.
  - WAIT: step_en=1. On each state_valid, increment the decimation counter. When the counter reaches max(decim,1), latch x/y/z in that same cycle, zero the counter, and go to PROJ.
  - PROJ: one cycle. Compute the projection below. If on-screen, load pix_* and go to WRITE. If off-screen, increment drop_cnt (saturating at 16'hFFFF) and go to WAIT.
  - WRITE: pix_valid=1 until pix_valid&&pix_ready. pix_x/pix_y/pix_color stay stable while stalled. After the transfer, the colour counter increments (wrapping 255→0) and the FSM goes to WAIT.
- step_en=0 in CLEAR, PROJ and WRITE. state_valid while step_en=0 is ignored.
- Projection:
  - Horizontal source h_src: X for XY/XZ, Y for YZ. Vertical source v_src: Y for XY, Z−Z_CENTER for XZ/YZ.
  - h = h_src >>> (FRAC_W − scale_shift), arithmetic shift, truncating toward −inf. v is computed the same way from v_src. Use 16-bit signed intermediates.
  - pix_x = SCREEN_W/2 + h. pix_y = SCREEN_H/2 − v.
  - A point is off-screen if pix_x ∉ [0, SCREEN_W−1] or pix_y ∉ [0, SCREEN_H−1]. There is no clamping.
- pix_color during a plot = colour counter value.
- Latency: capture at cycle N → PROJ at N+1 → pix_valid at N+2 (zero-wait acceptance).
- clear_req:
  - In WAIT: enter CLEAR on the next cycle, restarting at (0,0).
  - In PROJ/WRITE: latch it as pending and take it after the current point completes (write or drop).
  - In CLEAR: restart the sweep at (0,0) after the current transfer.
- A decimation change takes effect at the next compare. If the counter is already ≥ the new value, capture on the next state_valid.
- Reset mid-operation: the next cycle shows pix_valid=0 and the reset values. Any pending write is abandoned.
- The colour counter and drop_cnt are not cleared by clear_req.

Decomposition:
- Package lorenz_plot_pkg:
  - DATA_W, FRAC_W, Z_CENTER
  - proj_t enum (PROJ_XY, PROJ_XZ, PROJ_YZ)
  - plot_state_t enum (CLEAR, WAIT, PROJ, WRITE)
- Sub-module plot_project: combinational. Takes the latched x/y/z, proj_sel and scale_shift. Returns pix_x, pix_y and on_screen.

Test Plan:
- Reset, then pix_ready=1 constant → exactly 307200 transfers with colour 0. The first is (0,0) and the last is (639,479). busy falls and step_en rises the cycle after the last transfer.
- XY, scale_shift=3, decim=1, state_valid with x=1.0 (27'h0100000), y=2.0 → pix_x=328, pix_y=224, pix_color=0 at capture+2. The next point has colour 1.
- XZ, scale_shift=2, x=−3.5, z=25.0 → h=−14, v=0 → pix_x=306, pix_y=240.
- XY, scale_shift=3, x=−50.0 → pix_x=−80, so the point is dropped: no pix_valid and drop_cnt=1. The next on-screen point still plots.
- Backpressure: pix_ready=0 for 10 cycles during WRITE → pix_* held constant, step_en=0, and extra state_valid pulses ignored. The transfer completes on the first cycle pix_ready=1.
- decim=4 with 8 state_valid pulses → exactly 2 captures (the 4th and 8th pulses). clear_req during WRITE → the write completes, then the sweep restarts at (0,0).
